// File: rtl/rv_pkg.sv
// Shared fetch/control definitions: fetch FSM states, instruction size and
// the major opcodes also used by the control generator.
package rv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        TRAP
    } fetch_state_t;

    localparam int INSTR_BYTES = 4;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection: sequential increment or redirect target, plus a flag
// for a redirect whose target is not word aligned (PC then holds).
module pc_next_sel
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic            redirect_en,
    input  logic [XLEN-1:0] redirect_target,
    output logic [XLEN-1:0] next_pc,
    output logic            misalign
);

    // Sequential PC wraps naturally at 2^XLEN; a misaligned redirect keeps pc.
    always_comb begin
        next_pc  = pc + XLEN'(INSTR_BYTES);
        misalign = 1'b0;
        if (redirect_en) begin
            misalign = |redirect_target[1:0];
            next_pc  = misalign ? pc : redirect_target;
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program counter and one-at-a-time instruction fetch sequencer. Issues a
// request for pc_q, waits for the single response, holds the instruction
// for decode until accepted, then advances or redirects the PC.
module pc_fetch_ctrl
    import rv_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_en,
    input  logic [XLEN-1:0] redirect_target,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            instr_valid,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            instr_ready,
    output logic            misalign_trap,
    output logic            halted
);

    fetch_state_t    state;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] next_pc;
    logic            misalign;

    pc_next_sel #(.XLEN(XLEN)) u_next_sel (
        .pc              (pc_q),
        .redirect_en     (redirect_en),
        .redirect_target (redirect_target),
        .next_pc         (next_pc),
        .misalign        (misalign)
    );

    assign imem_req_addr = pc_q;

    // Fetch FSM with registered handshake/status outputs. Responses are only
    // looked at in WAIT, so stray or early responses capture nothing.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            pc_q           <= RESET_PC;
            imem_req_valid <= 1'b0;
            instr_valid    <= 1'b0;
            instr          <= '0;
            instr_pc       <= RESET_PC;
            misalign_trap  <= 1'b0;
            halted         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state          <= REQ;
                    imem_req_valid <= 1'b1;
                end
                REQ: begin
                    if (imem_req_ready) begin
                        state          <= WAIT;
                        imem_req_valid <= 1'b0;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        state       <= HOLD;
                        instr       <= imem_rsp_data;
                        instr_pc    <= pc_q;
                        instr_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        pc_q        <= next_pc;
                        if (misalign) begin
                            state         <= TRAP;
                            misalign_trap <= 1'b1;
                            halted        <= 1'b1;
                        end else begin
                            state          <= REQ;
                            imem_req_valid <= 1'b1;
                        end
                    end
                end
                TRAP: begin
                    state <= TRAP;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
